// File: rtl/sum_4bit.sv
// Registered unsigned adder: ripple-carry chain of full-adder cells feeding
// an output register, so the full WIDTH+1-bit sum (carry-out included) is kept.
module sum_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   x0,
  input  logic [WIDTH-1:0]   x1,
  output logic [WIDTH:0]     o,
  output logic               out_valid
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH:0]   carry_c;
  logic [SUM_W-1:0] sum_c;

  assign carry_c[0] = 1'b0;

  // One full-adder cell per bit; each carry ripples into the next stage.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p_c;
    assign p_c          = x0[i] ^ x1[i];
    assign sum_c[i]     = p_c ^ carry_c[i];
    assign carry_c[i+1] = (x0[i] & x1[i]) | (carry_c[i] & p_c);
  end

  assign sum_c[WIDTH] = carry_c[WIDTH];

  // Capture only on valid operands so idle (possibly undefined) inputs leave o alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o         <= SUM_W'(0);
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        o <= sum_c;
      end
    end
  end

endmodule

// File: tb/tb_sum_4bit.sv
// Directed self-checking bench for sum_4bit: reset, exhaustive sweep, hold,
// asynchronous mid-stream reset and back-to-back throughput.
module tb_sum_4bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] x0;
  logic [3:0] x1;
  logic [4:0] o;
  logic       out_valid;

  int n_checks = 0;
  int n_pass   = 0;

  sum_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x0        (x0),
    .x1        (x1),
    .o         (o),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
    in_valid = v;
    x0       = a;
    x1       = b;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 4'd15, 4'd15);

    // Reset holds outputs at zero despite valid operands and clock activity.
    repeat (3) step();
    check("rst_o", int'(o), 0);
    check("rst_valid", int'(out_valid), 0);

    rst_n = 1'b1;
    step();
    check("post_rst_o", int'(o), 30);
    check("post_rst_valid", int'(out_valid), 1);

    // Exhaustive sweep, one pair per cycle.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive(1'b1, 4'(a), 4'(b));
        step();
        check($sformatf("sum_%0d_%0d", a, b), int'(o), a + b);
        check($sformatf("valid_%0d_%0d", a, b), int'(out_valid), 1);
      end
    end

    // Carry-out boundary explicitly.
    drive(1'b1, 4'd7, 4'd8);
    step();
    check("carry_7_8", int'(o[4]), 0);
    drive(1'b1, 4'd8, 4'd8);
    step();
    check("carry_8_8", int'(o[4]), 1);

    // Hold: idle cycles keep the last sum and drop out_valid.
    drive(1'b1, 4'd9, 4'd6);
    step();
    check("hold_load_o", int'(o), 15);
    check("hold_load_valid", int'(out_valid), 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'd3, 4'd3);
      step();
      check($sformatf("hold_o_%0d", k), int'(o), 15);
      check($sformatf("hold_valid_%0d", k), int'(out_valid), 0);
    end
    drive(1'b0, 4'bxxxx, 4'bxxxx);
    step();
    check("hold_x_o", int'(o), 15);

    // Asynchronous reset between edges.
    drive(1'b1, 4'd15, 4'd15);
    step();
    check("pre_async_o", int'(o), 30);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_o", int'(o), 0);
    check("async_valid", int'(out_valid), 0);
    step();
    check("async_held_o", int'(o), 0);
    rst_n = 1'b1;
    drive(1'b1, 4'd1, 4'd2);
    step();
    check("after_async_o", int'(o), 3);
    check("after_async_valid", int'(out_valid), 1);

    // Back-to-back results in order.
    drive(1'b1, 4'd1, 4'd1);
    step();
    check("b2b_0_o", int'(o), 2);
    check("b2b_0_valid", int'(out_valid), 1);
    drive(1'b1, 4'd15, 4'd1);
    step();
    check("b2b_1_o", int'(o), 16);
    check("b2b_1_valid", int'(out_valid), 1);
    drive(1'b1, 4'd0, 4'd0);
    step();
    check("b2b_2_o", int'(o), 0);
    check("b2b_2_valid", int'(out_valid), 1);
    drive(1'b0, 4'd5, 4'd5);
    step();
    check("b2b_idle_o", int'(o), 0);
    check("b2b_idle_valid", int'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
